// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath and its downstream MAC stages.
package booth_pkg;

    localparam int PW_DEF = 32;
    localparam int AW_DEF = 40;
    localparam int CW_DEF = 8;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    // Clamp limits as raw bit patterns; callers keep the low aw bits.
    function automatic logic [127:0] sat_max(input int aw);
        sat_max = (128'd1 << (aw - 1)) - 128'd1;
    endfunction

    function automatic logic [127:0] sat_min(input int aw);
        sat_min = 128'd1 << (aw - 1);
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational saturating add of a sign-extended product into a wider signed accumulator.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic [AW-1:0] i_acc,
    input  logic [PW-1:0] i_p,
    output logic [AW-1:0] o_sum,
    output logic          o_sat_flag
);

    localparam logic [127:0] MAX_W = sat_max(AW);
    localparam logic [127:0] MIN_W = sat_min(AW);
    localparam logic [AW-1:0] MAX_V = MAX_W[AW-1:0];
    localparam logic [AW-1:0] MIN_V = MIN_W[AW-1:0];

    logic [AW:0] w_sum_ext;

    // One guard bit: the true sign sits in bit AW, so a mismatch with bit AW-1 is overflow.
    assign w_sum_ext  = {i_acc[AW-1], i_acc} + {{(AW + 1 - PW){i_p[PW-1]}}, i_p};
    assign o_sat_flag = w_sum_ext[AW] ^ w_sum_ext[AW-1];

    always_comb begin
        o_sum = w_sum_ext[AW-1:0];
        if (o_sat_flag) begin
            o_sum = w_sum_ext[AW] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates p_last-delimited product sequences into a saturating sum; result held on a
// valid/ready output while input is stalled (one bubble per sequence).
module booth_mac_accum
    import booth_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] p,
    input  logic          p_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] acc_out,
    output logic [CW-1:0] out_count,
    output logic          overflow
);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic [AW-1:0] r_acc_out;
    logic [CW-1:0] r_cnt_out;
    logic          r_ovf_out;

    logic          w_accept;
    logic          w_handshake;
    logic [AW-1:0] w_sum;
    logic          w_sat_flag;
    logic [CW-1:0] w_cnt_inc;
    logic          w_ovf_nxt;

    booth_sat_add #(
        .AW(AW),
        .PW(PW)
    ) u_sat_add (
        .i_acc      (r_acc),
        .i_p        (p),
        .o_sum      (w_sum),
        .o_sat_flag (w_sat_flag)
    );

    // Count sticks at all-ones; the sum keeps accumulating regardless.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
    assign w_ovf_nxt = r_ovf | w_sat_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            ACC: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && p_last) begin
                    w_next_state = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = ACC;
                end
            end
            default: w_next_state = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_acc_out <= '0;
            r_cnt_out <= '0;
            r_ovf_out <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            r_ovf <= w_ovf_nxt;
            if (p_last) begin
                r_acc_out <= w_sum;
                r_cnt_out <= w_cnt_inc;
                r_ovf_out <= w_ovf_nxt;
            end
        end else if (w_handshake) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

    assign acc_out   = r_acc_out;
    assign out_count = r_cnt_out;
    assign overflow  = r_ovf_out;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed bench for booth_mac_accum: AW=40 and AW=34 instances share one input stream.
module tb_booth_mac_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] p;
    logic        p_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_overflow;
    logic [39:0] a_acc_out;
    logic [7:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_overflow;
    logic [33:0] b_acc_out;
    logic [7:0]  b_out_count;

    always #5 clk = ~clk;

    booth_mac_accum #(.PW(32), .AW(40), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .p(p), .p_last(p_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .acc_out(a_acc_out),
        .out_count(a_out_count), .overflow(a_overflow));

    booth_mac_accum #(.PW(32), .AW(34), .CW(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .p(p), .p_last(p_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .acc_out(b_acc_out),
        .out_count(b_out_count), .overflow(b_overflow));

    int n_vec = 0;
    int n_err = 0;
    int n_bub = 0;
    bit checking = 0;
    bit count_bubbles = 0;
    bit capture = 0;
    longint cap_q[$];

    task automatic cmp(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one result slot per width, plain integer arithmetic with clamping.
    int     m_aw[2] = '{40, 34};
    bit     m_busy[2];
    longint m_acc[2];
    int     m_cnt[2];
    bit     m_ovf[2];
    longint m_res_acc[2];
    int     m_res_cnt[2];
    bit     m_res_ovf[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            longint s, hi, lo;
            hi = (longint'(1) <<< (m_aw[k] - 1)) - 1;
            lo = -(longint'(1) <<< (m_aw[k] - 1));
            if (rst) begin
                m_busy[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                m_res_acc[k] = 0; m_res_cnt[k] = 0; m_res_ovf[k] = 0;
            end else if (m_busy[k]) begin
                if (out_ready) begin
                    m_busy[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                end
            end else if (in_valid) begin
                s = m_acc[k] + longint'($signed(p));
                if (s > hi) begin s = hi; m_ovf[k] = 1; end
                if (s < lo) begin s = lo; m_ovf[k] = 1; end
                m_acc[k] = s;
                m_cnt[k] = (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
                if (p_last) begin
                    m_busy[k] = 1;
                    m_res_acc[k] = m_acc[k]; m_res_cnt[k] = m_cnt[k]; m_res_ovf[k] = m_ovf[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            cmp("a_in_ready", 64'(a_in_ready), 64'(!m_busy[0]));
            cmp("a_out_valid", 64'(a_out_valid), 64'(m_busy[0]));
            cmp("b_in_ready", 64'(b_in_ready), 64'(!m_busy[1]));
            cmp("b_out_valid", 64'(b_out_valid), 64'(m_busy[1]));
            if (m_busy[0]) begin
                cmp("a_acc_out", longint'($signed(a_acc_out)), m_res_acc[0]);
                cmp("a_out_count", 64'(a_out_count), 64'(m_res_cnt[0]));
                cmp("a_overflow", 64'(a_overflow), 64'(m_res_ovf[0]));
            end
            if (m_busy[1]) begin
                cmp("b_acc_out", longint'($signed(b_acc_out)), m_res_acc[1]);
                cmp("b_out_count", 64'(b_out_count), 64'(m_res_cnt[1]));
                cmp("b_overflow", 64'(b_overflow), 64'(m_res_ovf[1]));
            end
            if (capture && a_out_valid && out_ready) cap_q.push_back(longint'($signed(a_acc_out)));
        end
    end

    task automatic send(input logic signed [31:0] v, input bit last);
        int guard;
        guard = 0;
        p = v; p_last = last; in_valid = 1'b1;
        while (!a_in_ready && guard < 200) begin
            if (count_bubbles) n_bub++;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) cmp("send_timeout", 64'(guard), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input longint ea, input int ec, input bit eo,
                             input longint eb, input bit ebo);
        int guard;
        guard = 0;
        while (!a_out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        cmp({tag, "_valid"}, 64'(a_out_valid), 64'(1));
        cmp({tag, "_acc40"}, longint'($signed(a_acc_out)), ea);
        cmp({tag, "_cnt"}, 64'(a_out_count), 64'(ec));
        cmp({tag, "_ovf40"}, 64'(a_overflow), 64'(eo));
        cmp({tag, "_acc34"}, longint'($signed(b_acc_out)), eb);
        cmp({tag, "_ovf34"}, 64'(b_overflow), 64'(ebo));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; p = '0; p_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_in_ready", 64'(a_in_ready), 64'(1));
        cmp("rst_out_valid", 64'(a_out_valid), 64'(0));
        cmp("rst_acc_out", 64'(a_acc_out), 64'(0));
        cmp("rst_out_count", 64'(a_out_count), 64'(0));
        cmp("rst_overflow", 64'(a_overflow), 64'(0));
        rst = 1'b0;
        checking = 1;

        // Single-product sequence, one-cycle latency.
        send(126, 1'b1);
        in_valid = 1'b0;
        cmp("t1_latency", 64'(a_out_valid), 64'(1));
        check_res("t1", 126, 1, 0, 126, 0);
        take();

        send(1, 1'b0); send(-5000, 1'b0); send(4000, 1'b1);
        in_valid = 1'b0;
        check_res("t2", -999, 3, 0, -999, 0);
        cmp("t2_hex", 64'(a_acc_out), 64'(40'hFFFFFFFC19));
        take();
        cmp("t2_ready_after", 64'(a_in_ready), 64'(1));

        // Backpressure: held result, upstream waiting with p=7.
        send(10, 1'b1);
        p = 7; p_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmp("t3_hold_ready", 64'(a_in_ready), 64'(0));
            cmp("t3_hold_acc", longint'($signed(a_acc_out)), 10);
            cmp("t3_hold_cnt", 64'(a_out_count), 64'(1));
            @(posedge clk); #1;
        end
        take();
        send(7, 1'b1);
        in_valid = 1'b0;
        check_res("t3", 7, 1, 0, 7, 0);
        take();

        // Saturation on the 34-bit instance only.
        for (int i = 0; i < 9; i++) send(1073676289, i == 8);
        in_valid = 1'b0;
        check_res("t4_pos", 64'sd9663086601, 9, 0, 64'sd8589934591, 1);
        take();
        for (int i = 0; i < 9; i++) send(-1073709056, i == 8);
        in_valid = 1'b0;
        check_res("t4_neg", -64'sd9663381504, 9, 0, -64'sd8589934592, 1);
        take();
        send(5, 1'b1);
        in_valid = 1'b0;
        check_res("t4_clear", 5, 1, 0, 5, 0);
        take();

        // Reset mid-sequence, then reset while holding a result.
        send(100, 1'b0); send(200, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(3, 1'b1);
        in_valid = 1'b0;
        check_res("t5", 3, 1, 0, 3, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        cmp("t5_rst_out_valid", 64'(a_out_valid), 64'(0));
        cmp("t5_rst_in_ready", 64'(a_in_ready), 64'(1));
        rst = 1'b0;

        // Count saturation at 255 while the sum keeps growing.
        for (int i = 0; i < 300; i++) send(1, i == 299);
        in_valid = 1'b0;
        check_res("t7_cnt_sat", 300, 255, 0, 300, 0);
        take();

        // Back-to-back stream, lengths 1, 2, 4.
        n_bub = 0; count_bubbles = 1; capture = 1; out_ready = 1'b1;
        send(5, 1'b1);
        send(-2, 1'b0); send(9, 1'b1);
        send(1000, 1'b0); send(-1, 1'b0); send(-1, 1'b0); send(2, 1'b1);
        in_valid = 1'b0;
        cmp("t6_tail_bubble", 64'(a_in_ready), 64'(0));
        @(posedge clk); #1;
        cmp("t6_ready_back", 64'(a_in_ready), 64'(1));
        count_bubbles = 0; capture = 0; out_ready = 1'b0;
        cmp("t6_bubbles", 64'(n_bub), 64'(2));
        cmp("t6_results", 64'(cap_q.size()), 64'(3));
        if (cap_q.size() == 3) begin
            cmp("t6_res0", cap_q[0], 5);
            cmp("t6_res1", cap_q[1], 7);
            cmp("t6_res2", cap_q[2], 1000);
        end

        repeat (2) @(posedge clk);
        #1;
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mac_accum.md
Name: booth_mac_accum

Overview:
Downstream stage of the 16x16 signed Booth multiplier. Consumes the 32-bit signed product p one sample per accepted beat. Accumulates a sequence of products, delimited by p_last, into a saturating signed accumulator. Presents the dot-product result, product count and overflow flag on a valid/ready output handshake.

Parameters:
PW, 32, product width in bits; matches the multiplier output p.
AW, 40, accumulator width in bits; must satisfy AW > PW.
CW, 8, product-count width in bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  p/p_last are valid this cycle.
in_ready  output  1  stage can accept a product.
p  input  PW  signed two's-complement product from the multiplier.
p_last  input  1  marks the final product of a sequence.
out_valid  output  1  acc_out/out_count/overflow are valid.
out_ready  input  1  consumer accepts the result.
acc_out  output  AW  signed accumulated sum of the sequence.
out_count  output  CW  number of products in the sequence.
overflow  output  1  saturation occurred at least once in the sequence.

Behaviour:
- Reset state:
  - State ACC; internal accumulator = 0; count = 0; sticky ovf = 0.
  - Outputs: in_ready = 1, out_valid = 0, acc_out = 0, out_count = 0, overflow = 0.
- Clocking: one clock, clk. The synchronous active-high rst overrides every other input, including mid-sequence and while a result is held. Any partial sum is discarded.
- FSM state ACC:
  - in_ready = 1, out_valid = 0.
  - An accept is in_valid & in_ready.
  - On accept: acc <= sat_add(acc, sign-extended p); count <= count + 1, saturating at 2^CW-1; ovf <= ovf | sat_flag.
  - On accept with p_last = 1: the final sum, count and flag are registered into acc_out, out_count and overflow, and the FSM moves to OUT.
- FSM state OUT:
  - in_ready = 0, out_valid = 1.
  - acc_out, out_count and overflow are held stable until the handshake completes.
  - On out_ready = 1: return to ACC, clearing acc, count and ovf to 0. A new product can be accepted in the cycle after the handshake.
- Latency: the product accepted with p_last at edge n gives out_valid = 1 after edge n, i.e. visible in cycle n+1.
- Throughput: one product per cycle within a sequence, plus one bubble per sequence for the output handshake (minimum).
- Saturating add:
  - Form the sum in AW+1 bits. If bit AW differs from bit AW-1, clamp to the sign-appropriate limit and raise sat_flag.
  - Positive clamp is 2^(AW-1)-1; negative clamp is -2^(AW-1).
  - Later products continue from the clamped value.
- Boundary conditions:
  - A single-product sequence (p_last on the first beat) is legal; out_count = 1.
  - in_valid held high in OUT has no effect and no product is lost, because the upstream side holds its data while in_ready = 0.
  - out_ready asserted while in ACC is ignored.
  - When count reaches 2^CW-1 it sticks at that value; the accumulator keeps adding.
  - p and p_last are don't-care when in_valid = 0.

Decomposition:
- Shared package booth_pkg holds:
  - PW_DEF = 32, AW_DEF = 40, CW_DEF = 8.
  - The state enum {ACC, OUT}.
  - Functions for the AW-wide signed max/min clamp constants.
- One combinational sub-module, booth_sat_add:
  - Inputs: AW-bit acc and PW-bit p.
  - Outputs: AW-bit sum and sat_flag.
  - Instantiated once; it is also reusable by later MAC variants.

Test Plan:
1. Reset, then p=126 with p_last=1 (i.e. -126 * -1) -> one cycle later out_valid=1, acc_out=126, out_count=1, overflow=0.
2. Products 1, -5000, 4000, last on the third, out_ready=1 -> acc_out=40'hFFFFFFFC19 (-999), out_count=3, overflow=0; in_ready returns to 1 the cycle after the handshake.
3. Backpressure: complete a sequence, hold out_ready=0 for 5 cycles with in_valid=1 and p=7 -> in_ready=0 throughout, acc_out/out_count unchanged. Release out_ready, then send p=7 with last -> acc_out=7, out_count=1, confirming no carry-over.
4. Saturation with AW=34: 9 x p=1073676289 (32767^2), last on the 9th -> acc_out=8589934591, overflow=1, out_count=9. Negative case: 9 x p=-1073709056 -> acc_out=-8589934592, overflow=1. The next sequence of p=5 -> acc_out=5, overflow=0.
5. Reset mid-operation: accept 2 products, assert rst for one cycle, then send p=3 with last -> acc_out=3, out_count=1. Separately, assert rst while in OUT -> out_valid=0 and in_ready=1 on the next cycle.
6. Back-to-back stream: in_valid held high, out_ready held high, sequences of lengths 1, 2 and 4 -> all results correct. Exactly one in_ready=0 bubble per sequence.
